product_accumulator: RTL and testbench
======================================

// Module: product_accumulator
// PURPOSE
//   Downstream stage of the shift-add multiplier: sums a programmed number of products into
//   a saturating accumulator, then presents the sum on a valid/ready output handshake.
//   Products are taken on the multiplier's one-cycle finished pulse. The multiplier has no
//   backpressure, so products that arrive while no accumulation is open are dropped and flagged.
// PARAMETERS
//   BITS        8           multiplier operand width; product width is 2*BITS
//   ACC_BITS    2*BITS+2    accumulator/sum width (must be >= 2*BITS)
//   COUNT_BITS  4           width of term count; max terms = 2**COUNT_BITS-1
// PORTS
//   i_clock       in   1           clock; all logic on rising edge
//   i_reset_n     in   1           synchronous reset, active-low
//   i_clear       in   1           start new accumulation; latches i_terms
//   i_terms       in   COUNT_BITS  number of products to sum (0 allowed)
//   i_product     in   2*BITS      product from multiplier, unsigned
//   i_finished    in   1           product-valid pulse from multiplier
//   o_busy        out  1           1 while in ACCUM
//   o_sum         out  ACC_BITS    accumulator value; meaningful when o_valid
//   o_valid       out  1           result available (DONE state)
//   i_ready       in   1           consumer accepts result when o_valid & i_ready
//   o_overflow    out  1           sticky: accumulator saturated this run
//   o_dropped     out  1           sticky: product pulse arrived outside ACCUM this run
// BEHAVIOUR
//   - Reset (i_reset_n=0 at clock edge, any state): state=IDLE, o_sum=0, o_valid=0,
//     o_busy=0, o_overflow=0, o_dropped=0, remaining count=0. Overrides all other inputs.
//   - States: IDLE, ACCUM, DONE. All outputs registered; o_busy=(state==ACCUM),
//     o_valid=(state==DONE).
//   - i_clear has priority over everything but reset, in any state: acc<=0, overflow<=0,
//     dropped<=0, remaining<=i_terms; next state ACCUM if i_terms!=0, else DONE (sum 0).
//     An i_finished in the same cycle as i_clear is ignored: not added, not flagged.
//     An i_ready in the same cycle is ignored; any pending result is discarded.
//   - ACCUM, i_finished=1: acc <= acc + zero-extended i_product, computed ACC_BITS+1 wide.
//     On carry-out, acc <= all ones and o_overflow <= 1. Once saturated, acc stays all ones.
//     remaining <= remaining-1. If remaining==1 the next state is DONE, so o_valid rises
//     on the edge that adds the last product (1-cycle latency from the last pulse).
//   - ACCUM, i_finished=0: hold. There is no timeout.
//   - DONE: o_sum and o_overflow held stable while o_valid=1 and i_ready=0.
//     o_valid & i_ready at an edge -> IDLE; o_valid=0 next cycle; o_sum keeps its value.
//   - i_finished in IDLE or DONE (without i_clear): product discarded, o_dropped <= 1,
//     o_sum unchanged.
//   - Flags clear only on i_clear or reset. i_terms is sampled only on i_clear.
// TESTING
//   1. Reset in ACCUM after 2 of 4 products: i_reset_n=0 for 1 edge -> all outputs 0,
//      IDLE; a later i_finished sets o_dropped=1.
//   2. BITS=8, i_clear with i_terms=3, products 10,20,30 on separate pulses -> o_valid=1
//      the cycle after the 3rd pulse, o_sum=60, o_overflow=0; i_ready=1 -> o_valid=0 next cycle.
//   3. ACC_BITS=18, i_terms=5, product 65025 x5 -> after 4 products o_sum=260100;
//      after the 5th o_sum=262143 and o_overflow=1.
//   4. DONE with i_ready=0 for 10 cycles and a stray i_finished (product 99) -> o_valid and
//      o_sum held, o_dropped=1; then i_ready=1 -> IDLE.
//   5. i_clear in ACCUM after one product (50), with i_finished asserted in the same cycle,
//      i_terms=2 -> acc=0, then products 7,8 -> o_sum=15, o_dropped=0.
//   6. i_clear with i_terms=0 -> o_valid=1 next cycle, o_sum=0; back-to-back pulses on
//      consecutive cycles with i_terms=15 accumulate correctly.

Source files
------------

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - saturating sum of a programmed number of multiplier products
// Results are presented on a valid/ready handshake; pulses with no open accumulation are flagged.
module product_accumulator #(
  parameter int BITS       = 8,
  parameter int ACC_BITS   = 2*BITS+2,
  parameter int COUNT_BITS = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_clear,
  input  logic [COUNT_BITS-1:0] i_terms,
  input  logic [2*BITS-1:0]     i_product,
  input  logic                  i_finished,
  output logic                  o_busy,
  output logic [ACC_BITS-1:0]   o_sum,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_overflow,
  output logic                  o_dropped
);

  localparam int PAD = ACC_BITS + 1 - 2*BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state, state_next;
  logic [ACC_BITS-1:0]   acc, acc_next;
  logic                  overflow, overflow_next;
  logic                  dropped, dropped_next;
  logic [COUNT_BITS-1:0] remaining, remaining_next;
  logic [ACC_BITS:0]     sum_wide;

  // One extra bit so the carry-out of the add is visible for saturation.
  assign sum_wide = {1'b0, acc} + {{PAD{1'b0}}, i_product};

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state     <= IDLE;
      acc       <= '0;
      overflow  <= 1'b0;
      dropped   <= 1'b0;
      remaining <= '0;
    end else begin
      state     <= state_next;
      acc       <= acc_next;
      overflow  <= overflow_next;
      dropped   <= dropped_next;
      remaining <= remaining_next;
    end
  end

  always_comb begin
    state_next     = state;
    acc_next       = acc;
    overflow_next  = overflow;
    dropped_next   = dropped;
    remaining_next = remaining;

    if (i_clear) begin
      acc_next       = '0;
      overflow_next  = 1'b0;
      dropped_next   = 1'b0;
      remaining_next = i_terms;
      state_next     = (i_terms != '0) ? ACCUM : DONE;
    end else begin
      case (state)
        ACCUM: begin
          if (i_finished) begin
            if (sum_wide[ACC_BITS]) begin
              acc_next      = '1;
              overflow_next = 1'b1;
            end else begin
              acc_next = sum_wide[ACC_BITS-1:0];
            end
            remaining_next = remaining - COUNT_BITS'(1);
            if (remaining == COUNT_BITS'(1)) state_next = DONE;
          end
        end
        DONE: begin
          if (i_finished) dropped_next = 1'b1;
          if (i_ready) state_next = IDLE;
        end
        default: begin
          if (i_finished) dropped_next = 1'b1;
        end
      endcase
    end
  end

  assign o_busy     = (state == ACCUM);
  assign o_valid    = (state == DONE);
  assign o_sum      = acc;
  assign o_overflow = overflow;
  assign o_dropped  = dropped;

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - directed bench for product_accumulator
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_product_accumulator;

  localparam int BITS       = 8;
  localparam int ACC_BITS   = 2*BITS+2;
  localparam int COUNT_BITS = 4;

  logic                  clock = 1'b0;
  logic                  reset_n;
  logic                  clear;
  logic [COUNT_BITS-1:0] terms;
  logic [2*BITS-1:0]     product;
  logic                  finished;
  logic                  busy;
  logic [ACC_BITS-1:0]   sum;
  logic                  valid;
  logic                  ready;
  logic                  overflow;
  logic                  dropped;

  int checks   = 0;
  int failures = 0;

  product_accumulator #(
    .BITS(BITS), .ACC_BITS(ACC_BITS), .COUNT_BITS(COUNT_BITS)
  ) dut (
    .i_clock(clock), .i_reset_n(reset_n), .i_clear(clear), .i_terms(terms),
    .i_product(product), .i_finished(finished), .o_busy(busy), .o_sum(sum),
    .o_valid(valid), .i_ready(ready), .o_overflow(overflow), .o_dropped(dropped)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse(input int p);
    finished = 1'b1;
    product  = p[2*BITS-1:0];
    tick();
    finished = 1'b0;
  endtask

  task automatic start(input int n);
    clear = 1'b1;
    terms = n[COUNT_BITS-1:0];
    tick();
    clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; clear = 1'b0; terms = '0; product = '0; finished = 1'b0; ready = 1'b0;
    #1;
    tick();
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_sum", sum, 0);
    reset_n = 1'b1;

    // 1: reset mid-accumulation
    start(4);
    check("t1_busy", busy, 1);
    pulse(100);
    pulse(200);
    check("t1_partial", sum, 300);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("t1_busy0", busy, 0);
    check("t1_valid0", valid, 0);
    check("t1_sum0", sum, 0);
    check("t1_ovf0", overflow, 0);
    check("t1_drop0", dropped, 0);
    pulse(55);
    check("t1_drop1", dropped, 1);
    check("t1_sum_kept", sum, 0);

    // 2: three products
    start(3);
    pulse(10);
    pulse(20);
    check("t2_valid_early", valid, 0);
    pulse(30);
    check("t2_valid", valid, 1);
    check("t2_sum", sum, 60);
    check("t2_ovf", overflow, 0);
    check("t2_drop_cleared", dropped, 0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("t2_valid_off", valid, 0);
    check("t2_sum_kept", sum, 60);

    // 3: saturation
    start(5);
    for (int i = 0; i < 4; i++) pulse(65025);
    check("t3_sum4", sum, 260100);
    check("t3_ovf4", overflow, 0);
    pulse(65025);
    check("t3_sum5", sum, 262143);
    check("t3_ovf5", overflow, 1);
    check("t3_valid", valid, 1);
    ready = 1'b1;
    tick();
    ready = 1'b0;

    // 4: held in DONE with a stray pulse
    start(1);
    pulse(5);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) pulse(99);
      else tick();
    end
    check("t4_valid_held", valid, 1);
    check("t4_sum_held", sum, 5);
    check("t4_drop", dropped, 1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("t4_idle_valid", valid, 0);
    check("t4_idle_busy", busy, 0);

    // 5: clear during ACCUM with a coincident pulse
    start(2);
    pulse(50);
    check("t5_partial", sum, 50);
    clear = 1'b1; terms = 4'd2; finished = 1'b1; product = 16'd99;
    tick();
    clear = 1'b0; finished = 1'b0;
    check("t5_sum_zero", sum, 0);
    check("t5_busy", busy, 1);
    pulse(7);
    pulse(8);
    check("t5_valid", valid, 1);
    check("t5_sum", sum, 15);
    check("t5_drop", dropped, 0);

    // 6: zero terms, then 15 back-to-back pulses
    start(0);
    check("t6_valid_zero", valid, 1);
    check("t6_sum_zero", sum, 0);
    check("t6_busy_zero", busy, 0);
    start(15);
    finished = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      product = 16'(i);
      tick();
    end
    finished = 1'b0;
    check("t6_valid", valid, 1);
    check("t6_sum", sum, 120);
    check("t6_drop", dropped, 0);
    check("t6_ovf", overflow, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
